// File: rtl/input_debouncer.sv
// input_debouncer
//   Qualifies an already-synchronized level: out follows in only after in has
//   held a new value for STABLE_CYCLES consecutive samples. Each qualified
//   change produces a registered one-cycle rise or fall strobe. Aborted
//   qualifications (glitches) are counted in a saturating counter.
//
//   Optional feature macro: INPUT_DEBOUNCER_GLITCH_CNT_EN
//     defined   : glitch counter and clear are implemented
//     undefined : glitch_count is tied to 0 and clear is ignored
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   STABLE   | out matches the last qualified level, no candidate pending
//   QUALIFY  | in differs from out, counting consecutive samples of it
module input_debouncer #(
    parameter int   STABLE_CYCLES    = 1000,
    parameter logic RESET_LEVEL      = 1'b0,
    parameter int   GLITCH_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in,
    input  logic                        clear,
    output logic                        out,
    output logic                        rise,
    output logic                        fall,
    output logic                        busy,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // cnt value at which the next matching sample completes qualification
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("input_debouncer: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic             w_diff;
    logic             w_glitch;

    assign w_diff = in ^ r_out;

    // State, counter and debounced level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_out   <= RESET_LEVEL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Next-state logic: qualify a changed level or abandon it on a glitch
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_glitch    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (w_diff) begin
                    if (STABLE_CYCLES == 1) begin
                        // a single sample is already enough to qualify
                        w_out_nxt = in;
                    end else begin
                        w_state_nxt = ST_QUALIFY;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (!w_diff) begin
                    w_glitch    = 1'b1;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_out_nxt   = in;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Edge strobes and busy flag, registered alongside the level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_rise <= w_out_nxt & ~r_out;
            r_fall <= ~w_out_nxt & r_out;
            r_busy <= (w_state_nxt == ST_QUALIFY);
        end
    end

    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [GLITCH_CNT_WIDTH-1:0] r_glitch_cnt;

    // Saturating glitch counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else if (clear) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_WIDTH'(1);
        end
    end

    assign glitch_count = r_glitch_cnt;
`else
    logic w_unused;

    assign w_unused     = &{1'b0, clear, w_glitch};
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: five instances with different
// parameter sets; stimulus pushes cycle-tagged expectations, a negedge
// monitor pops and compares them.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    typedef struct {
        int   inst;
        int   cyc;
        logic o;
        logic r;
        logic f;
        logic b;
        int   gc;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic [4:0] rst_v;
    logic [4:0] in_v;
    logic [4:0] clr_v;
    logic [4:0] out_v;
    logic [4:0] rise_v;
    logic [4:0] fall_v;
    logic [4:0] busy_v;
    logic [2:0] gc0, gc2, gc3, gc4;
    logic [1:0] gc1;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    input_debouncer #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_CNT_WIDTH(3)) u0 (
        .clk(clk), .rst_n(rst_v[0]), .in(in_v[0]), .clear(clr_v[0]),
        .out(out_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .busy(busy_v[0]),
        .glitch_count(gc0));
    input_debouncer #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_CNT_WIDTH(2)) u1 (
        .clk(clk), .rst_n(rst_v[1]), .in(in_v[1]), .clear(clr_v[1]),
        .out(out_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .busy(busy_v[1]),
        .glitch_count(gc1));
    input_debouncer #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b0), .GLITCH_CNT_WIDTH(3)) u2 (
        .clk(clk), .rst_n(rst_v[2]), .in(in_v[2]), .clear(clr_v[2]),
        .out(out_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .busy(busy_v[2]),
        .glitch_count(gc2));
    input_debouncer #(.STABLE_CYCLES(8), .RESET_LEVEL(1'b0), .GLITCH_CNT_WIDTH(3)) u3 (
        .clk(clk), .rst_n(rst_v[3]), .in(in_v[3]), .clear(clr_v[3]),
        .out(out_v[3]), .rise(rise_v[3]), .fall(fall_v[3]), .busy(busy_v[3]),
        .glitch_count(gc3));
    input_debouncer #(.STABLE_CYCLES(3), .RESET_LEVEL(1'b1), .GLITCH_CNT_WIDTH(3)) u4 (
        .clk(clk), .rst_n(rst_v[4]), .in(in_v[4]), .clear(clr_v[4]),
        .out(out_v[4]), .rise(rise_v[4]), .fall(fall_v[4]), .busy(busy_v[4]),
        .glitch_count(gc4));

    function automatic int get_gc(input int i);
        case (i)
            0:       return int'(gc0);
            1:       return int'(gc1);
            2:       return int'(gc2);
            3:       return int'(gc3);
            default: return int'(gc4);
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // expectation for instance i, dc cycles after the current one
    task automatic push(input string name, input int i, input int dc,
                        input logic o, input logic r, input logic f,
                        input logic b, input int gc);
        exp_t e;
        e.inst = i;
        e.cyc  = cyc + dc;
        e.o    = o;
        e.r    = r;
        e.f    = f;
        e.b    = b;
        e.gc   = GC_EN ? gc : 0;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due this cycle, flag overdue ones
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rise_v[i] && fall_v[i]) begin
                errors++;
                $display("FAIL rise_fall_excl inst=%0d cyc=%0d got rise=1 fall=1 want not both", i, cyc);
            end
        end
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                int  n;
                int  agc;
                n   = sb[k].inst;
                agc = get_gc(n);
                checks++;
                if (out_v[n] !== sb[k].o || rise_v[n] !== sb[k].r || fall_v[n] !== sb[k].f ||
                    busy_v[n] !== sb[k].b || agc != sb[k].gc) begin
                    errors++;
                    $display("FAIL %s inst=%0d cyc=%0d got out/rise/fall/busy=%b%b%b%b gc=%0d want %b%b%b%b gc=%0d",
                             sb[k].name, n, cyc, out_v[n], rise_v[n], fall_v[n], busy_v[n], agc,
                             sb[k].o, sb[k].r, sb[k].f, sb[k].b, sb[k].gc);
                end
                sb.delete(k);
            end else if (sb[k].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s inst=%0d missed check at cyc=%0d got none want checked", sb[k].name, sb[k].inst, sb[k].cyc);
                sb.delete(k);
            end
        end
    end

    initial begin
        rst_v = '0;
        in_v  = '0;
        clr_v = '0;
        step(1);

        // reset: RESET_LEVEL=1 instance holds its reset outputs while in toggles
        for (int j = 0; j < 6; j++) begin
            in_v[4] = ~in_v[4];
            push("reset_hold", 4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            step(1);
        end
        in_v[4] = 1'b1;
        rst_v   = '1;
        push("reset_release", 4, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        push("reset_release", 4, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(4);

        // clean rising edge, STABLE_CYCLES=4
        push("rise_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int d = 1; d <= 3; d++) push("rise_busy", 0, d, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        push("rise_edge", 0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        push("rise_after", 0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        in_v[0] = 1'b1;
        step(6);

        // clean falling edge
        for (int d = 1; d <= 3; d++) push("fall_busy", 0, d, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        push("fall_edge", 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        push("fall_after", 0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        in_v[0] = 1'b0;
        step(6);

        // five glitches of 3 samples each, then clear
        for (int k = 1; k <= 5; k++) begin
            for (int d = 1; d <= 3; d++) push("glitch_busy", 0, d, 1'b0, 1'b0, 1'b0, 1'b1, k - 1);
            push("glitch_count", 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, k);
            in_v[0] = 1'b1;
            step(3);
            in_v[0] = 1'b0;
            step(2);
        end
        push("clear", 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        clr_v[0] = 1'b1;
        step(1);
        clr_v[0] = 1'b0;
        step(2);

        // saturation with a 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            for (int d = 1; d <= 3; d++)
                push("sat_busy", 1, d, 1'b0, 1'b0, 1'b0, 1'b1, (k - 1 > 3) ? 3 : k - 1);
            push("sat_count", 1, 4, 1'b0, 1'b0, 1'b0, 1'b0, (k > 3) ? 3 : k);
            in_v[1] = 1'b1;
            step(3);
            in_v[1] = 1'b0;
            step(2);
        end
        // clear on the same edge as a glitch
        for (int d = 1; d <= 3; d++) push("prio_busy", 1, d, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        push("clear_priority", 1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        in_v[1] = 1'b1;
        step(3);
        in_v[1] = 1'b0;
        clr_v[1] = 1'b1;
        step(1);
        clr_v[1] = 1'b0;
        step(2);

        // STABLE_CYCLES=1, in toggling every cycle
        for (int j = 0; j < 8; j++) begin
            logic v;
            v = (j % 2 == 0);
            push("degen_follow", 2, 1, v, v, ~v, 1'b0, 0);
            in_v[2] = v;
            step(1);
        end
        push("degen_settle", 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(3);

        // reset at cnt=5 of an 8-cycle qualification, then requalify
        for (int d = 1; d <= 4; d++) push("rstq_busy", 3, d, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        push("rstq_reset", 3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        push("rstq_reset", 3, 6, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        in_v[3] = 1'b1;
        step(5);
        rst_v[3] = 1'b0;
        step(2);
        rst_v[3] = 1'b1;
        for (int d = 1; d <= 7; d++) push("rstq_requal", 3, d, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        push("rstq_edge", 3, 8, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        push("rstq_after", 3, 9, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(12);

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s inst=%0d never checked cyc=%0d got none want checked", sb[0].name, sb[0].inst, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
